controlpb20000: RTL and testbench

Sequencing controller for the 20 kHz low-pass biquad datapath `filtropb20000`: it sits directly upstream of it and drives all seven register enables and the three mux-bank selects. On each `start` pulse it runs one direct-form-II sample update: shift the delay line, compute the state f(k), then compute the output y(k). It reports completion with `done`. It has no data path of its own; all arithmetic happens in the filter's registered multiply-accumulate unit.

---
 rtl/controlpb20000.sv | 130 +++++++++++++
 tb/tb_controlpb20000.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlpb20000.sv
// Sequencer for the filtropb20000 biquad datapath.
// Runs shift, f(k) and y(k) steps as issue/write pairs.
module controlpb20000 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [1:0] selmuxC,
  output logic [2:0] selmuxZ,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [3:0] {
    IDLE,
    SHIFT,
    A1_ISS,
    A1_WR,
    A2_ISS,
    A2_WR,
    Y1_ISS,
    Y1_WR,
    Y2_ISS,
    Y2_WR,
    Y3_ISS,
    Y3_WR,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  // State register; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Sticky overrun: start seen while a sample is in flight.
  always_ff @(posedge clk) begin
    if (reset)
      overrun <= 1'b0;
    else if (start && state != IDLE)
      overrun <= 1'b1;
  end

  // Next state: linear walk, only IDLE looks at start.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = SHIFT;
      SHIFT:   nxt = A1_ISS;
      A1_ISS:  nxt = A1_WR;
      A1_WR:   nxt = A2_ISS;
      A2_ISS:  nxt = A2_WR;
      A2_WR:   nxt = Y1_ISS;
      Y1_ISS:  nxt = Y1_WR;
      Y1_WR:   nxt = Y2_ISS;
      Y2_ISS:  nxt = Y2_WR;
      Y2_WR:   nxt = Y3_ISS;
      Y3_ISS:  nxt = Y3_WR;
      Y3_WR:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output decode; write states keep the issue selects held.
  always_comb begin
    en1     = 1'b0;
    en2     = 1'b0;
    en3     = 1'b0;
    en4     = 1'b0;
    en5     = 1'b0;
    en6     = 1'b0;
    en7     = 1'b0;
    selmuxS = 3'd0;
    selmuxC = 2'd0;
    selmuxZ = 3'd0;
    done    = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      SHIFT: begin
        en3 = 1'b1;
        en4 = 1'b1;
      end
      A1_ISS, A1_WR: begin
        selmuxS = 3'd1;
        selmuxC = 2'd0;
        selmuxZ = 3'd3;
        en5     = (state == A1_WR);
      end
      A2_ISS, A2_WR: begin
        selmuxS = 3'd2;
        selmuxC = 2'd1;
        selmuxZ = 3'd0;
        en2     = (state == A2_WR);
      end
      Y1_ISS, Y1_WR: begin
        selmuxS = 3'd0;
        selmuxC = 2'd2;
        selmuxZ = 3'd4;
        en6     = (state == Y1_WR);
      end
      Y2_ISS, Y2_WR: begin
        selmuxS = 3'd1;
        selmuxC = 2'd3;
        selmuxZ = 3'd1;
        en7     = (state == Y2_WR);
      end
      Y3_ISS, Y3_WR: begin
        selmuxS = 3'd2;
        selmuxC = 2'd2;
        selmuxZ = 3'd2;
        en1     = (state == Y3_WR);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controlpb20000.sv
// Bench for controlpb20000 with a Q12 behavioural datapath.
// Scoreboard queues hold expected vectors, done cycles and yk.
module tb_controlpb20000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       en1, en2, en3, en4, en5, en6, en7;
  logic [2:0] selmuxS;
  logic [1:0] selmuxC;
  logic [2:0] selmuxZ;
  logic       busy, done, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [16:0] v;
    logic [16:0] m;
  } exp_t;

  exp_t vq[$];
  int   dq[$];
  int   yq[$];

  controlpb20000 dut (
    .clk(clk), .reset(reset), .start(start),
    .en1(en1), .en2(en2), .en3(en3), .en4(en4),
    .en5(en5), .en6(en6), .en7(en7),
    .selmuxS(selmuxS), .selmuxC(selmuxC),
    .selmuxZ(selmuxZ), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  wire [6:0]  en   = {en7, en6, en5, en4, en3, en2, en1};
  wire [16:0] actv = {en, selmuxS, selmuxC, selmuxZ, busy, done};

  // Q12 datapath model: 4096 = 1.0
  localparam int NA1 = 2048;
  localparam int NA2 = -1024;
  localparam int B0  = 1024;
  localparam int B1  = 2048;
  int uk = 0;
  int yk, fk, fk1, fk2, ac1, ac2, ac3, res;
  int ms, mc, mz;

  always_comb begin
    ms = 0;
    mc = 0;
    mz = 0;
    case (selmuxS)
      3'd0: ms = fk;
      3'd1: ms = fk1;
      3'd2: ms = fk2;
      default: ms = 0;
    endcase
    case (selmuxC)
      2'd0: mc = NA1;
      2'd1: mc = NA2;
      2'd2: mc = B0;
      default: mc = B1;
    endcase
    case (selmuxZ)
      3'd0: mz = ac1;
      3'd1: mz = ac2;
      3'd2: mz = ac3;
      3'd3: mz = uk;
      default: mz = 0;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      yk <= 0; fk <= 0; fk1 <= 0; fk2 <= 0;
      ac1 <= 0; ac2 <= 0; ac3 <= 0; res <= 0;
    end else begin
      res <= ((ms * mc) >>> 12) + mz;
      if (en1) yk  <= res;
      if (en2) fk  <= res;
      if (en3) fk1 <= fk;
      if (en4) fk2 <= fk1;
      if (en5) ac1 <= res;
      if (en6) ac2 <= res;
      if (en7) ac3 <= res;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Expected outputs c cycles after start; selects only where defined.
  function automatic exp_t vec(input int c);
    exp_t e;
    logic [6:0] ee;
    logic [2:0] s, z;
    logic [1:0] cc;
    logic sel_ok;
    ee = '0; s = '0; cc = '0; z = '0; sel_ok = 1'b0;
    case (c)
      1:  ee = 7'b0001100;
      2:  begin s = 1; cc = 0; z = 3; sel_ok = 1; end
      3:  ee = 7'b0010000;
      4:  begin s = 2; cc = 1; z = 0; sel_ok = 1; end
      5:  ee = 7'b0000010;
      6:  begin s = 0; cc = 2; z = 4; sel_ok = 1; end
      7:  ee = 7'b0100000;
      8:  begin s = 1; cc = 3; z = 1; sel_ok = 1; end
      9:  ee = 7'b1000000;
      10: begin s = 2; cc = 2; z = 2; sel_ok = 1; end
      11: ee = 7'b0000001;
      12: ;
      default: sel_ok = 1;
    endcase
    e.v = {ee, s, cc, z, (c >= 1 && c <= 12), (c == 12)};
    e.m = {7'h7f, {8{sel_ok}}, 2'b11};
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (actv !== 17'd0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h ov=%b want 0", actv, overrun);
    end
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    e = vec(5);
    n_checks++;
    if ((actv & e.m) !== (e.v & e.m)) begin
      n_fail++;
      $display("FAIL reset_pre: got %h want %h", actv, e.v);
    end
    do_reset(2);
    n_checks++;
    if (actv !== 17'd0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h ov=%b want 0", actv, overrun);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (en !== 7'd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_quiet: cyc %0d en=%b busy=%b want 0", i, en, busy);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    start = 1'b1;
    for (int c = 1; c <= 13; c++) vq.push_back(vec(c));
    tick();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      e = vq.pop_front();
      n_checks++;
      if ((actv & e.m) !== (e.v & e.m)) begin
        n_fail++;
        $display("FAIL single_c%0d: got %h want %h", c, actv & e.m, e.v & e.m);
      end
      if (c < 13) tick();
    end
  endtask

  task automatic test_impulse();
    real f, f1, f2, y;
    int n;
    f1 = 0.0;
    f2 = 0.0;
    for (int k = 0; k < 4; k++) begin
      f = ((k == 0) ? 1.0 : 0.0) + 0.5 * f1 - 0.25 * f2;
      y = 0.25 * f + 0.5 * f1 + 0.25 * f2;
      f2 = f1;
      f1 = f;
      yq.push_back($rtoi(y * 4096.0));
      uk = (k == 0) ? 4096 : 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      uk = 0;
      n = 3;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      n_checks++;
      if (!done) begin
        n_fail++;
        $display("FAIL impulse_timeout: sample %0d no done", k);
        void'(yq.pop_front());
      end else begin
        int ey;
        ey = yq.pop_front();
        n_checks++;
        if (yk !== ey || n !== 12) begin
          n_fail++;
          $display("FAIL impulse_y%0d: got %0d at c%0d want %0d at c12", k, yk, n, ey);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    dq.push_back(12);
    dq.push_back(25);
    for (int c = 0; c <= 27; c++) begin
      if (done) begin
        n_checks++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_done: got c%0d want none", c);
        end else begin
          int ec;
          ec = dq.pop_front();
          if (c !== ec) begin
            n_fail++;
            $display("FAIL b2b_done: got c%0d want c%0d", c, ec);
          end
        end
      end
      start = (c == 0 || c == 13);
      tick();
      start = 1'b0;
    end
    n_checks++;
    if (dq.size() != 0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: left %0d ov=%b want 0 0", dq.size(), overrun);
      dq.delete();
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    int n;
    dq.push_back(12);
    for (int c = 0; c <= 20; c++) begin
      if (done) begin
        n_checks++;
        if (dq.size() == 0 || dq[0] != c) begin
          n_fail++;
          $display("FAIL ovr_done: got c%0d want c12", c);
        end
        if (dq.size() != 0) void'(dq.pop_front());
      end
      if (c >= 1) begin
        e = vec(c);
        n_checks++;
        if ((actv & e.m) !== (e.v & e.m)) begin
          n_fail++;
          $display("FAIL ovr_seq_c%0d: got %h want %h", c, actv & e.m, e.v & e.m);
        end
      end
      n_checks++;
      if (overrun !== (c >= 7)) begin
        n_fail++;
        $display("FAIL ovr_flag_c%0d: got %b want %b", c, overrun, c >= 7);
      end
      start = (c == 0 || c == 6);
      tick();
      start = 1'b0;
    end
    n_checks++;
    if (dq.size() != 0) begin
      n_fail++;
      $display("FAIL ovr_missing_done: got none want c12");
      dq.delete();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (!done || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got done=%b ov=%b want 1 1", done, overrun);
    end
    tick();
    do_reset(1);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_start_in_done();
    for (int c = 0; c <= 20; c++) begin
      n_checks++;
      if (done !== (c == 12) || overrun !== (c >= 13)) begin
        n_fail++;
        $display("FAIL done_start_c%0d: got d=%b ov=%b want %b %b",
                 c, done, overrun, c == 12, c >= 13);
      end
      if (c >= 13) begin
        n_checks++;
        if (busy !== 1'b0 || en !== 7'd0) begin
          n_fail++;
          $display("FAIL done_start_idle_c%0d: got busy=%b en=%b want 0", c, busy, en);
        end
      end
      start = (c == 0 || c == 12);
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_impulse();
    test_back_to_back();
    test_overrun();
    test_start_in_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
